pc_ras: RTL and testbench
=========================

PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 Parameter RW, default 16, data/address width in bits; SHALL be at least 4.
REQ-002 Parameter RAS_DEPTH, default 8, return-address stack entries; SHALL be a power of two, at least 2.
REQ-003 Parameter RST_VEC, default 0, PC value loaded on reset.
REQ-004 Parameter IRQ_VEC, default 1, PC value loaded on interrupt entry.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  synchronous active-low reset.
REQ-007 i_bus  input  RW  jump target (absolute) or two's-complement offset (relative).
REQ-008 i_c_pc_inc  input  1  advance PC by 1.
REQ-009 i_c_pc_ie  input  1  load PC from i_bus.
REQ-010 i_c_pc_rel  input  1  PC <= PC + i_bus.
REQ-011 i_c_pc_call  input  1  push PC+1, load PC from i_bus.
REQ-012 i_c_pc_ret  input  1  pop stack top into PC.
REQ-013 i_c_pc_irq  input  1  interrupt request, level, held by control unit until taken.
REQ-014 i_c_pc_iret  input  1  return from interrupt.
REQ-015 i_stall  input  1  freeze all state except reset.
REQ-016 o_pc  output  RW  current program counter.
REQ-017 o_epc  output  RW  saved exception PC.
REQ-018 o_irq_act  output  1  interrupt handler active.
REQ-019 o_ras_empty / o_ras_full  output  1 each  stack occupancy = 0 / = RAS_DEPTH.
REQ-020 o_ras_ovf / o_ras_unf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-021 When i_stall=1 and i_rst_n=1, no register SHALL change.
REQ-022 When not stalled, exactly one action per cycle, priority: irq (only if o_irq_act=0) > iret > ret > call > ie > rel > inc; none asserted -> PC holds.
REQ-023 Single-cycle latency: the new o_pc value SHALL be visible the cycle after the control edge.
REQ-024 All PC arithmetic SHALL be modulo 2^RW; PC=2^RW-1 with inc SHALL wrap to 0; rel SHALL sign-interpret i_bus at full RW width.
REQ-025 irq taken: o_epc <= o_pc, o_pc <= IRQ_VEC, o_irq_act <= 1; irq while o_irq_act=1 SHALL be ignored (no nesting) and the next lower-priority action SHALL proceed.
REQ-026 iret with o_irq_act=1: o_pc <= o_epc, o_irq_act <= 0; iret with o_irq_act=0 SHALL behave as no action (PC holds).
REQ-027 call: push (o_pc+1) mod 2^RW, o_pc <= i_bus, occupancy +1.
REQ-028 call when full: oldest entry SHALL be overwritten (circular), occupancy stays RAS_DEPTH, o_ras_ovf <= 1.
REQ-029 ret when non-empty: o_pc <= top entry, occupancy -1.
REQ-030 ret when empty: o_pc <= o_pc+1, occupancy stays 0, o_ras_unf <= 1.
REQ-031 Simultaneous call and ret: ret wins per REQ-022; call SHALL be discarded.
REQ-032 Sticky flags SHALL clear only on reset.
REQ-033 Stack contents SHALL be unaffected by irq, iret, ie, rel, inc.

Reset
REQ-034 i_rst_n=0 at a rising edge SHALL override stall and all controls: o_pc=RST_VEC, o_epc=0, o_irq_act=0, occupancy 0 (o_ras_empty=1, o_ras_full=0), o_ras_ovf=0, o_ras_unf=0.
REQ-035 Stack storage SHALL not require reset; reset mid-call/ret SHALL leave no residual occupancy.

Structure
REQ-036 RW default and vector defaults SHALL live in the shared config include; no block-local copies.
REQ-037 LIFO SHALL be a sub-module pc_ras_stack (push, pop, top, empty, full, circular pointer, saturating count).
REQ-038 Storage SHALL be flops (RAS_DEPTH x RW); no memory macro.

Verification
REQ-039 Reset then inc x3 -> o_pc 0,1,2,3; hold PC=0xFFFF (RW=16), inc -> 0x0000.
REQ-040 PC=0x0010, rel i_bus=0xFFFC -> o_pc=0x000C; ie i_bus=0x1234 -> 0x1234.
REQ-041 PC=0x0100, call 0x0200, call 0x0300, ret, ret -> o_pc 0x0200,0x0300,0x0201,0x0101; o_ras_empty=1 at end.
REQ-042 RAS_DEPTH=8: 9 calls -> o_ras_full=1, o_ras_ovf=1; 8 rets return newest 8 addresses; 9th ret -> PC+1, o_ras_unf=1.
REQ-043 PC=0x0040, irq -> o_pc=0x0001, o_epc=0x0040, o_irq_act=1; irq again ignored; iret -> 0x0040, o_irq_act=0.
REQ-044 i_stall=1 with call asserted -> no change; i_rst_n=0 with i_stall=1 -> all REQ-034 reset values.

Source files
------------

// File: rtl/pc_ras_pkg.sv
// pc_ras_pkg: shared widths, vectors and action decode for the PC / return-address-stack block
package pc_ras_pkg;
  localparam int RW_DEF = 16;
  localparam int RAS_DEPTH_DEF = 8;
  localparam int RST_VEC_DEF = 0;
  localparam int IRQ_VEC_DEF = 1;
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_IRQ,
    ACT_IRET,
    ACT_RET,
    ACT_CALL,
    ACT_IE,
    ACT_REL,
    ACT_INC
  } act_e;
  function automatic act_e pick_act(input logic stall, input logic irq_act, input logic irq,
                                    input logic iret, input logic ret, input logic call,
                                    input logic ie, input logic rel, input logic inc);
    return stall ? ACT_NONE :
           (irq && !irq_act) ? ACT_IRQ :
           iret ? (irq_act ? ACT_IRET : ACT_NONE) :
           ret ? ACT_RET :
           call ? ACT_CALL :
           ie ? ACT_IE :
           rel ? ACT_REL :
           inc ? ACT_INC : ACT_NONE;
  endfunction
endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular flop-based LIFO with saturating occupancy, oldest entry overwritten when full
module pc_ras_stack
  import pc_ras_pkg::*;
#(
  parameter int W = RW_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW:0] count;
  logic [AW-1:0] top_idx;
  assign top_idx = ptr - AW'(1);
  assign top = mem[top_idx];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  always_ff @(posedge i_clk)
    if (push) mem[ptr] <= din;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      count <= full ? count : count + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= top_idx;
      count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_ras.sv
// pc_ras: program counter with call/return stack, single-level interrupt entry/return and sticky stack errors
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int RST_VEC = RST_VEC_DEF,
  parameter int IRQ_VEC = IRQ_VEC_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [RW-1:0] i_bus,
  input  logic          i_c_pc_inc,
  input  logic          i_c_pc_ie,
  input  logic          i_c_pc_rel,
  input  logic          i_c_pc_call,
  input  logic          i_c_pc_ret,
  input  logic          i_c_pc_irq,
  input  logic          i_c_pc_iret,
  input  logic          i_stall,
  output logic [RW-1:0] o_pc,
  output logic [RW-1:0] o_epc,
  output logic          o_irq_act,
  output logic          o_ras_empty,
  output logic          o_ras_full,
  output logic          o_ras_ovf,
  output logic          o_ras_unf
);
  act_e act;
  logic [RW-1:0] pc_inc, pc_nxt, ras_top;
  logic push, pop;
  assign act = pick_act(i_stall, o_irq_act, i_c_pc_irq, i_c_pc_iret, i_c_pc_ret,
                        i_c_pc_call, i_c_pc_ie, i_c_pc_rel, i_c_pc_inc);
  assign pc_inc = o_pc + RW'(1);
  assign push = i_rst_n && act == ACT_CALL;
  assign pop = i_rst_n && act == ACT_RET;
  always_comb
    pc_nxt = act == ACT_IRQ ? RW'(IRQ_VEC) :
             act == ACT_IRET ? o_epc :
             act == ACT_RET ? (o_ras_empty ? pc_inc : ras_top) :
             (act == ACT_CALL || act == ACT_IE) ? i_bus :
             act == ACT_REL ? o_pc + i_bus :
             act == ACT_INC ? pc_inc : o_pc;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pc <= RW'(RST_VEC);
      o_epc <= '0;
      o_irq_act <= 1'b0;
      o_ras_ovf <= 1'b0;
      o_ras_unf <= 1'b0;
    end else begin
      o_pc <= pc_nxt;
      if (act == ACT_IRQ) o_epc <= o_pc;
      o_irq_act <= act == ACT_IRQ ? 1'b1 : act == ACT_IRET ? 1'b0 : o_irq_act;
      o_ras_ovf <= o_ras_ovf | (push & o_ras_full);
      o_ras_unf <= o_ras_unf | (pop & o_ras_empty);
    end
  end
  pc_ras_stack #(.W(RW), .DEPTH(RAS_DEPTH)) u_stack (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .push   (push),
    .pop    (pop),
    .din    (pc_inc),
    .top    (ras_top),
    .empty  (o_ras_empty),
    .full   (o_ras_full)
  );
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed self-checking bench for pc_ras with hand-computed expectations
module tb_pc_ras;
  localparam logic [6:0] INC = 7'b0000001, REL = 7'b0000010, IE = 7'b0000100, CALL = 7'b0001000;
  localparam logic [6:0] RET = 7'b0010000, IRET = 7'b0100000, IRQ = 7'b1000000, NONE = 7'b0;
  logic clk = 1'b0;
  logic rst_n, stall, inc, ie, rel, call, ret, irq, iret;
  logic [15:0] bus, pc, epc;
  logic irq_act, empty, full, ovf, unf;
  int errors = 0;
  int checks = 0;
  pc_ras dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bus(bus),
    .i_c_pc_inc(inc), .i_c_pc_ie(ie), .i_c_pc_rel(rel), .i_c_pc_call(call),
    .i_c_pc_ret(ret), .i_c_pc_irq(irq), .i_c_pc_iret(iret), .i_stall(stall),
    .o_pc(pc), .o_epc(epc), .o_irq_act(irq_act),
    .o_ras_empty(empty), .o_ras_full(full), .o_ras_ovf(ovf), .o_ras_unf(unf)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [6:0] c, input logic [15:0] b);
    {irq, iret, ret, call, ie, rel, inc} = c;
    bus = b;
    @(posedge clk);
    #1;
    {irq, iret, ret, call, ie, rel, inc} = NONE;
    bus = '0;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_flags(input string tag, input logic [4:0] exp);
    chk(tag, {11'b0, irq_act, empty, full, ovf, unf}, {11'b0, exp});
  endtask
  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    step(NONE, 16'h0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk_flags("rst_flags", 5'b01000);
    rst_n = 1'b1;
    step(INC, 16'h0); chk("inc1", pc, 16'h0001);
    step(INC, 16'h0); chk("inc2", pc, 16'h0002);
    step(INC, 16'h0); chk("inc3", pc, 16'h0003);
    step(NONE, 16'h0); chk("hold", pc, 16'h0003);
    step(IE, 16'hFFFF); chk("ie_ffff", pc, 16'hFFFF);
    step(INC, 16'h0); chk("inc_wrap", pc, 16'h0000);
    step(IE, 16'h0010); chk("ie_10", pc, 16'h0010);
    step(REL, 16'hFFFC); chk("rel_neg", pc, 16'h000C);
    step(REL | INC, 16'h0005); chk("rel_over_inc", pc, 16'h0011);
    step(IE | REL | INC, 16'h1234); chk("ie_1234", pc, 16'h1234);
    step(IE, 16'h0100);
    step(CALL | IE, 16'h0200); chk("call1", pc, 16'h0200);
    step(CALL, 16'h0300); chk("call2", pc, 16'h0300);
    step(RET, 16'h0); chk("ret1", pc, 16'h0201);
    step(RET, 16'h0); chk("ret2", pc, 16'h0101);
    chk_flags("ret_empty", 5'b01000);
    stall = 1'b1;
    step(CALL, 16'h5555); chk("stall_pc", pc, 16'h0101);
    chk_flags("stall_flags", 5'b01000);
    stall = 1'b0;
    step(CALL, 16'h0200); chk("call3", pc, 16'h0200);
    step(CALL | RET, 16'h0700); chk("callret_pc", pc, 16'h0102);
    chk_flags("callret_flags", 5'b01000);
    for (int k = 0; k < 9; k++) begin
      step(CALL, 16'h1000 + 16'(k) * 16'h10);
      if (k == 7) chk_flags("full8", 5'b00100);
    end
    chk("call9_pc", pc, 16'h1080);
    chk_flags("full9", 5'b00110);
    for (int j = 0; j < 8; j++) begin
      step(RET, 16'h0);
      chk("ret_deep", pc, 16'h1001 + 16'(7 - j) * 16'h10);
    end
    chk_flags("drained", 5'b01010);
    step(RET, 16'h0); chk("ret_unf_pc", pc, 16'h1002);
    chk_flags("unf", 5'b01011);
    step(IE, 16'h0040);
    step(IRQ | CALL, 16'h0999); chk("irq_pc", pc, 16'h0001);
    chk("irq_epc", epc, 16'h0040);
    chk_flags("irq_flags", 5'b11011);
    step(IRQ | INC, 16'h0); chk("irq_nest_pc", pc, 16'h0002);
    chk("irq_nest_epc", epc, 16'h0040);
    step(IRET, 16'h0); chk("iret_pc", pc, 16'h0040);
    chk_flags("iret_flags", 5'b01011);
    step(IRET | INC, 16'h0); chk("iret_idle", pc, 16'h0040);
    step(CALL, 16'h0500);
    step(IRQ, 16'h0);
    step(IRET, 16'h0);
    step(RET, 16'h0); chk("ras_kept", pc, 16'h0041);
    step(IRQ, 16'h0);
    step(CALL, 16'h0300);
    stall = 1'b1;
    rst_n = 1'b0;
    step(CALL | IRQ, 16'h0777);
    chk("rst2_pc", pc, 16'h0000);
    chk("rst2_epc", epc, 16'h0000);
    chk_flags("rst2_flags", 5'b01000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
